// File: rtl/mem_access_unit.sv
// Load/store sequencer between the datapath MEM step and a byte-addressed word memory port.
// Takes one request at a time, lane-aligns stores, extends loads, and reports misalignment/timeout via err.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] tcnt_q;

  logic [1:0]  req_off;
  logic        legal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext_d;
  logic        timeout_hit;

  assign req_off = req_addr[1:0];

  // Decode legality and store lane placement straight from the incoming request.
  always_comb begin
    legal_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    if (req_is_store) begin
      case (req_funct3)
        3'b000: begin
          legal_d = 1'b1;
          be_d    = 4'b0001 << req_off;
          wdata_d = req_wdata << {req_off, 3'b000};
        end
        3'b001: begin
          legal_d = ~req_off[0];
          be_d    = 4'b0011 << req_off;
          wdata_d = req_wdata << {req_off, 3'b000};
        end
        3'b010:  legal_d = (req_off == 2'b00);
        default: legal_d = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: legal_d = 1'b1;
        3'b001, 3'b101: legal_d = ~req_off[0];
        3'b010:         legal_d = (req_off == 2'b00);
        default:        legal_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext_d = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext_d = {24'd0, load_byte};
      3'b001:  load_ext_d = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext_d = {16'd0, load_half};
      3'b010:  load_ext_d = mem_rdata;
      default: load_ext_d = 32'd0;
    endcase
  end

  // Terminal ACCESS cycle without a response; a response in that same cycle takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((tcnt_q + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      mem_address_q <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      be_q          <= 4'd0;
      wdata_q       <= 32'd0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= 32'd0;
      tcnt_q        <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            is_store_q    <= req_is_store;
            funct3_q      <= req_funct3;
            off_q         <= req_off;
            mem_address_q <= {req_addr[31:2], 2'b00};
            tcnt_q        <= 32'd0;
            if (legal_d) begin
              mem_read_q  <= ~req_is_store;
              mem_write_q <= req_is_store;
              be_q        <= req_is_store ? be_d : 4'b1111;
              wdata_q     <= req_is_store ? wdata_d : 32'd0;
              state_q     <= ACCESS;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
              state_q <= DONE;
            end
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            rdata_q     <= is_store_q ? 32'd0 : load_ext_d;
            state_q     <= DONE;
          end else if (timeout_hit) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= 32'd0;
            state_q     <= DONE;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: requests push expected memory accesses and completions,
// while a memory responder/monitor and a completion monitor pop and compare independently.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          len;
  } done_exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } mem_exp_t;

  done_exp_t dq[$];
  mem_exp_t  mq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration: resp_delay = ACCESS cycle number carrying mem_resp.
  bit          resp_en    = 1'b0;
  int          resp_delay = 1;
  logic [31:0] resp_word  = 32'd0;
  bit          force_resp = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory side: answers strobes and checks every access against the expected queue.
  initial begin : responder
    int       acc_cnt;
    bit       prev_strobe;
    mem_exp_t cur;
    mem_exp_t e;
    acc_cnt     = 0;
    prev_strobe = 1'b0;
    mem_resp    = 1'b0;
    mem_rdata   = 32'd0;
    cur         = '{rd: 1'b0, wr: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, chk_wd: 1'b0};
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (!prev_strobe) begin
          if (mq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem: rd=%0b wr=%0b addr=0x%08h, expected no access",
                     mem_read, mem_write, mem_address);
          end else begin
            e = mq.pop_front();
            check32("mem_read", {31'd0, mem_read}, {31'd0, e.rd});
            check32("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
            check32("mem_address", mem_address, e.addr);
            check32("mem_byte_enable", {28'd0, mem_byte_enable}, {28'd0, e.be});
            if (e.chk_wd) check32("mem_wdata", mem_wdata, e.wdata);
          end
          cur = '{rd: mem_read, wr: mem_write, addr: mem_address, be: mem_byte_enable,
                  wdata: mem_wdata, chk_wd: 1'b1};
        end else begin
          check32("mem_hold_addr", mem_address, cur.addr);
          check32("mem_hold_be", {28'd0, mem_byte_enable}, {28'd0, cur.be});
          check32("mem_hold_wdata", mem_wdata, cur.wdata);
        end
        acc_cnt++;
        mem_resp  = resp_en && (acc_cnt == resp_delay);
        mem_rdata = mem_resp ? resp_word : 32'hDEAD_BEEF;
        prev_strobe = 1'b1;
      end else begin
        acc_cnt     = 0;
        mem_resp    = force_resp;
        mem_rdata   = resp_word;
        prev_strobe = 1'b0;
      end
    end
  end

  // Completion side: pops the expected result on each done pulse.
  initial begin : done_monitor
    int        run_len;
    bit        prev_done;
    done_exp_t e;
    run_len   = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len   = 0;
        prev_done = 1'b0;
      end else begin
        if (mem_read || mem_write) run_len++;
        if (done) begin
          check32("done_width", {31'd0, prev_done}, 32'd0);
          if (dq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: err=%0b rdata=0x%08h, expected no completion", err, rdata);
          end else begin
            e = dq.pop_front();
            check32("err", {31'd0, err}, {31'd0, e.err});
            check32("rdata", rdata, e.rdata);
            check32("strobe_cycles", run_len, e.len);
          end
          run_len = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] word,
                        input bit e_err, input logic [31:0] e_rd, input bit e_mem,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input int e_len, input int e_lat);
    int lat;
    int guard;
    resp_en    = (dly > 0);
    resp_delay = dly;
    resp_word  = word;
    if (e_mem)
      mq.push_back('{rd: !st, wr: st, addr: {a[31:2], 2'b00}, be: e_be, wdata: e_wd, chk_wd: st});
    dq.push_back('{err: e_err, rdata: e_rd, len: e_len});
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check32("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat > 50) begin
        $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", lat, e_lat);
        break;
      end
    end
    check32("latency", lat, e_lat);
    @(posedge clk); #1;
    check32("mem_queue_drained", mq.size(), 32'd0);
    mq.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check32("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check32("rst_be", {28'd0, mem_byte_enable}, 32'd0);
    check32("rst_address", mem_address, 32'd0);
    check32("rst_wdata", mem_wdata, 32'd0);
    check32("rst_done_err", {30'd0, done, err}, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //     st f3     addr          wdata         dly word          err rdata         mem be       mem_wdata     len lat
    do_req(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0,        0, 32'h0,        1, 4'b1000, 32'hA500_0000, 2, 3); // sb
    do_req(0, 3'b000, 32'h0000_0102, 32'h0,        1, 32'h12F3_5678, 0, 32'hFFFF_FFF3, 1, 4'b1111, 32'h0,        1, 2); // lb
    do_req(0, 3'b100, 32'h0000_0102, 32'h0,        1, 32'h12F3_5678, 0, 32'h0000_00F3, 1, 4'b1111, 32'h0,        1, 2); // lbu
    do_req(0, 3'b000, 32'h0000_0101, 32'h0,        2, 32'h12F3_5678, 0, 32'h0000_0056, 1, 4'b1111, 32'h0,        2, 3); // lb off1
    do_req(0, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h12F3_5678, 0, 32'h0000_0012, 1, 4'b1111, 32'h0,        1, 2); // lbu off3
    do_req(0, 3'b001, 32'h0000_0102, 32'h0,        3, 32'h8001_1234, 0, 32'hFFFF_8001, 1, 4'b1111, 32'h0,        3, 4); // lh
    do_req(0, 3'b101, 32'h0000_0100, 32'h0,        1, 32'h8001_9234, 0, 32'h0000_9234, 1, 4'b1111, 32'h0,        1, 2); // lhu
    do_req(0, 3'b001, 32'h0000_0100, 32'h0,        1, 32'h8001_9234, 0, 32'hFFFF_9234, 1, 4'b1111, 32'h0,        1, 2); // lh low
    do_req(0, 3'b010, 32'h0000_0100, 32'h0,        1, 32'h8001_1234, 0, 32'h8001_1234, 1, 4'b1111, 32'h0,        1, 2); // lw
    do_req(1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 1, 32'h0,        0, 32'h0,        1, 4'b1100, 32'hBEEF_0000, 1, 2); // sh
    do_req(1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 2, 32'h0,        0, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 2, 3); // sw
    do_req(1, 3'b000, 32'h0000_0200, 32'h1234_5677, 1, 32'h0,        0, 32'h0,        1, 4'b0001, 32'h1234_5677, 1, 2); // sb off0
    // Illegal requests: done+err one cycle after accept, no memory traffic.
    do_req(0, 3'b010, 32'h0000_0101, 32'h0,        1, 32'h0,        1, 32'h0,        0, 4'b0000, 32'h0,        0, 1); // lw misaligned
    do_req(1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 1, 32'h0,        1, 32'h0,        0, 4'b0000, 32'h0,        0, 1); // sh misaligned
    do_req(0, 3'b101, 32'h0000_0101, 32'h0,        1, 32'h0,        1, 32'h0,        0, 4'b0000, 32'h0,        0, 1); // lhu misaligned
    do_req(0, 3'b011, 32'h0000_0100, 32'h0,        1, 32'h0,        1, 32'h0,        0, 4'b0000, 32'h0,        0, 1); // bad load f3
    do_req(1, 3'b100, 32'h0000_0100, 32'h0,        1, 32'h0,        1, 32'h0,        0, 4'b0000, 32'h0,        0, 1); // bad store f3
    // Timeout after 4 ACCESS cycles, then a retry whose response lands on the terminal cycle.
    do_req(0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 32'h0,        1, 4'b1111, 32'h0,        4, 5);
    do_req(0, 3'b010, 32'h0000_0100, 32'h0,        4, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1, 4'b1111, 32'h0,       4, 5);

    // Reset in the middle of an ACCESS: strobes drop, no done, late mem_resp ignored.
    resp_en = 1'b0;
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0300, be: 4'b1111, wdata: 32'h0, chk_wd: 1'b0});
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check32("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check32("abort_done", {31'd0, done}, 32'd0);
    force_resp = 1'b1;
    @(posedge clk); #1;
    force_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("late_resp_done", {31'd0, done}, 32'd0);
      check32("late_resp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    end
    @(posedge clk); #1;
    do_req(0, 3'b000, 32'h0000_0300, 32'h0,        1, 32'h0000_8000, 0, 32'h0000_0000, 1, 4'b1111, 32'h0,        1, 2);
    do_req(0, 3'b001, 32'h0000_0302, 32'h0,        1, 32'h7FFF_0000, 0, 32'h0000_7FFF, 1, 4'b1111, 32'h0,        1, 2);

    repeat (3) @(posedge clk);
    check32("done_queue_drained", dq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
